// File: rtl/if_stage_if.sv
// if_stage_if
//   Handshake bundle around the fetch stage: the instruction-memory request and
//   response channels plus the instruction stream towards decode.
//   master : the fetch stage (drives requests and the decode stream)
//   slave  : the environment (memory returns ready/responses, decode returns ready)
//
//   imem_req_valid / imem_req_ready / imem_addr   request channel
//   imem_rsp_valid / imem_rsp_data                in-order response channel
//   id_valid / id_ready / id_instruction / id_pc  stream to decode
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_instruction, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_instruction, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );
endinterface

// File: rtl/if_stage.sv
// if_stage
//   Instruction-fetch stage. Owns the PC, issues in-order word requests to
//   instruction memory under a credit limit, buffers returned words in a small
//   FIFO and streams {instruction, pc} to decode. A redirect flushes the FIFO,
//   reloads the PC and marks every in-flight response for discard.
//
//   Ports:
//     clk            system clock, rising edge
//     rst_n          asynchronous active-low reset
//     fetch_en       1 = new requests allowed
//     redirect_valid one-cycle flush/restart pulse
//     redirect_pc    restart address (bits [1:0] ignored)
//     bus            if_stage_if.master: imem request/response and decode stream
//     perf_fetched   decode handshakes           (IF_PERF_CNT_EN only)
//     perf_stall     cycles id_valid && !id_ready (IF_PERF_CNT_EN only)
//
//   Build option: define IF_PERF_CNT_EN to add the two performance counters.
//
//   state | meaning
//   IDLE  | no new requests; outstanding responses are still accepted
//   FETCH | issue sequential word requests while credit allows
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  state_t         state;
  state_t         state_next;
  logic [31:0]    pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  discard_cnt;
  logic [CW-1:0]  fifo_count;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  aq_wr;
  logic [AW-1:0]  aq_rd;
  logic [31:0]    fifo_data [FIFO_DEPTH];
  logic [31:0]    fifo_pc   [FIFO_DEPTH];
  logic [31:0]    aq        [FIFO_DEPTH];

  logic [CW:0]    credit_used;
  logic           req_valid;
  logic           req_hs;
  logic           rsp_acc;
  logic           rsp_keep;
  logic           id_valid;
  logic           pop;
  logic           unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Slots already committed: words waiting in the FIFO plus words still in
  // flight. Keeping the sum below the depth means every response has a slot.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en) state_next = FETCH;
      end
      FETCH: begin
        req_valid = !redirect_valid && (credit_used < DEPTH_C);
        if (!fetch_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_hs   = req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_acc  = bus.imem_rsp_valid && (outstanding != '0);
  // Responses landing in the redirect cycle belong to the old stream.
  assign rsp_keep = rsp_acc && !redirect_valid && (discard_cnt == '0);
  assign id_valid = (fifo_count != '0);
  // A decode handshake in the redirect cycle is swallowed by the flush.
  assign pop      = id_valid && bus.id_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
    end else begin
      if (redirect_valid)  pc <= {redirect_pc[31:2], 2'b00};
      else if (req_hs)     pc <= pc + 32'd4;

      outstanding <= outstanding + CW'(req_hs) - CW'(rsp_acc);

      // Everything still in flight after this edge is stale. outstanding
      // already counts the responses marked by an earlier redirect, so the
      // pending discard count must not be added on top of it.
      if (redirect_valid)
        discard_cnt <= outstanding - CW'(rsp_acc);
      else if (rsp_acc && (discard_cnt != '0))
        discard_cnt <= discard_cnt - CW'(1);

      // The address queue mirrors every accepted request, including the ones
      // that will be discarded, so it stays aligned with the response order.
      if (req_hs)  aq_wr <= aq_wr + AW'(1);
      if (rsp_acc) aq_rd <= aq_rd + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect_valid) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (rsp_keep) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) aq[aq_wr] <= pc;
    if (rsp_keep) begin
      fifo_data[wr_ptr] <= bus.imem_rsp_data;
      fifo_pc[wr_ptr]   <= aq[aq_rd];
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc;
  assign bus.id_valid       = id_valid;
  // Gated so the decode-facing data reads as zero whenever nothing is valid.
  assign bus.id_instruction = id_valid ? fifo_data[rd_ptr] : '0;
  assign bus.id_pc          = id_valid ? fifo_pc[rd_ptr]   : '0;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (id_valid && bus.id_ready)  perf_fetched <= perf_fetched + 32'd1;
      if (id_valid && !bus.id_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_rsp_has_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (outstanding != '0)
  );

  a_fifo_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    rsp_keep |-> ({1'b0, fifo_count} < DEPTH_C)
  );
`endif

endmodule
